// File: rtl/c7b_pkg.sv
// Shared types for the c7bicu request arbiter.
// Master ids, default outstanding depth, ID-queue entry.
package c7b_pkg;

  localparam int C7B_OUTST = 2;

  typedef enum logic {
    C7B_MST_IFU = 1'b0,
    C7B_MST_AUX = 1'b1
  } c7b_mst_e;

  typedef struct packed {
    c7b_mst_e id;
    logic     kill;
  } c7b_ent_t;

endpackage

// File: rtl/c7bicu_arb_if.sv
// Master/ICU side signal bundle of the c7bicu arbiter.
// slave: arbiter view, master: requester/ICU view.
interface c7bicu_arb_if #(
  parameter int ADDR_W = 32
) ();

  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_flush;
  logic              m0_ack;
  logic              m0_data_valid;
  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_ack;
  logic              m1_data_valid;
  logic              arb_icu_req;
  logic [ADDR_W-1:0] arb_icu_addr;
  logic              icu_arb_ack;
  logic              icu_arb_data_valid;
  logic              arb_err;

  modport slave (
    input  m0_req,
    input  m0_addr,
    input  m0_flush,
    input  m1_req,
    input  m1_addr,
    input  icu_arb_ack,
    input  icu_arb_data_valid,
    output m0_ack,
    output m0_data_valid,
    output m1_ack,
    output m1_data_valid,
    output arb_icu_req,
    output arb_icu_addr,
    output arb_err
  );

  modport master (
    output m0_req,
    output m0_addr,
    output m0_flush,
    output m1_req,
    output m1_addr,
    output icu_arb_ack,
    output icu_arb_data_valid,
    input  m0_ack,
    input  m0_data_valid,
    input  m1_ack,
    input  m1_data_valid,
    input  arb_icu_req,
    input  arb_icu_addr,
    input  arb_err
  );

endinterface

// File: rtl/c7bicu_arb_idq.sv
// In-order owner-id queue for accepted ICU requests.
// Kill marks every stored IFU entry; a same-cycle push stays live.
module c7bicu_arb_idq
  import c7b_pkg::*;
#(
  parameter int DEPTH = C7B_OUTST
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  c7b_mst_e push_id_i,
  input  logic     pop_i,
  input  logic     kill_i,
  output logic     full_o,
  output logic     empty_o,
  output c7b_ent_t head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  c7b_ent_t      mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic [PW:0]   cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign full_o  = (cnt_q == FULL);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (kill_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem_q[i].id == C7B_MST_IFU) begin
            mem_q[i].kill <= 1'b1;
          end
        end
      end
      if (push_i) begin
        mem_q[wr_q] <= '{id: push_id_i, kill: 1'b0};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/c7bicu_arb.sv
// Two-master arbiter for the ICU ic1/ic2 port with owner tracking.
// `define C7BICU_ARB_RR_EN for round-robin, else fixed m0 priority.
module c7bicu_arb
  import c7b_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OUTST  = C7B_OUTST
) (
  input logic           clk,
  input logic           reset,
  c7bicu_arb_if.slave   bus
);

  logic              lock_q;
  logic              lock_d;
  c7b_mst_e          lock_id_q;
  c7b_mst_e          lock_id_d;
  logic              lock_eff;
  logic              gnt_vld;
  c7b_mst_e          gnt_id;
  logic [ADDR_W-1:0] gnt_addr;
  logic              icu_req;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              flush_gnt;
  c7b_ent_t          head;

`ifdef C7BICU_ARB_RR_EN
  c7b_mst_e rr_q;
  c7b_mst_e rr_d;
`endif

  // A lock only counts while its owner keeps requesting
  assign lock_eff = lock_q &
    (lock_id_q == C7B_MST_AUX ? bus.m1_req : bus.m0_req);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = C7B_MST_IFU;
    if (lock_eff) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id_q;
    end else if (bus.m0_req && bus.m1_req) begin
      gnt_vld = 1'b1;
`ifdef C7BICU_ARB_RR_EN
      gnt_id  = rr_q;
`else
      gnt_id  = C7B_MST_IFU;
`endif
    end else if (bus.m0_req) begin
      gnt_vld = 1'b1;
      gnt_id  = C7B_MST_IFU;
    end else if (bus.m1_req) begin
      gnt_vld = 1'b1;
      gnt_id  = C7B_MST_AUX;
    end
  end

  always_comb begin
    gnt_addr = '0;
    if (gnt_vld) begin
      gnt_addr = (gnt_id == C7B_MST_AUX) ?
        bus.m1_addr : bus.m0_addr;
    end
  end

  // A full queue still accepts when a response frees a slot
  assign pop     = bus.icu_arb_data_valid & ~empty;
  assign icu_req = gnt_vld & (~full | pop);
  assign push    = icu_req & bus.icu_arb_ack;

  assign bus.arb_icu_req  = icu_req;
  assign bus.arb_icu_addr = gnt_addr;
  assign bus.m0_ack = push & (gnt_id == C7B_MST_IFU);
  assign bus.m1_ack = push & (gnt_id == C7B_MST_AUX);

  assign bus.m0_data_valid = pop & ~head.kill &
    (head.id == C7B_MST_IFU) & ~bus.m0_flush;
  assign bus.m1_data_valid = pop & ~head.kill &
    (head.id == C7B_MST_AUX);
  assign bus.arb_err = bus.icu_arb_data_valid & empty;

  assign flush_gnt = bus.m0_flush & (gnt_id == C7B_MST_IFU);

  always_comb begin
    lock_d    = (lock_eff | (icu_req & ~bus.icu_arb_ack)) &
                ~push & ~flush_gnt;
    lock_id_d = gnt_id;
  end

`ifdef C7BICU_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (push) begin
      rr_d = (gnt_id == C7B_MST_IFU) ? C7B_MST_AUX : C7B_MST_IFU;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= C7B_MST_IFU;
`ifdef C7BICU_ARB_RR_EN
      rr_q      <= C7B_MST_IFU;
`endif
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`ifdef C7BICU_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  c7bicu_arb_idq #(
    .DEPTH (OUTST)
  ) u_idq (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .push_id_i (gnt_id),
    .pop_i     (pop),
    .kill_i    (bus.m0_flush),
    .full_o    (full),
    .empty_o   (empty),
    .head_o    (head)
  );

endmodule

// File: tb/tb_c7bicu_arb.sv
// Bench for c7bicu_arb: vector table, corner sequences, random vs model.
// Honours C7BICU_ARB_RR_EN in its reference model.
module tb_c7bicu_arb;

  localparam int OUTST = 2;
`ifdef C7BICU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;

  c7bicu_arb_if #(.ADDR_W(32)) bus ();

  c7bicu_arb #(
    .ADDR_W (32),
    .OUTST  (OUTST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit id;
    bit kill;
  } ment_t;

  ment_t mq[$];
  bit    lk_v;
  bit    lk_id;
  bit    rr;
  bit    g_v;
  bit    g_id;
  bit    pop_m;
  bit    e_m0a, e_m0d, e_m1a, e_m1d, e_req, e_err;
  logic [31:0] e_addr;

  typedef struct {
    bit          r0;
    logic [31:0] a0;
    bit          fl;
    bit          r1;
    logic [31:0] a1;
    bit          ak;
    bit          dv;
    logic [5:0]  eo;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [37:0] got,
                     input logic [37:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    lk_v  = 1'b0;
    lk_id = 1'b0;
    rr    = 1'b0;
  endtask

  task automatic model_comb();
    bit locked;
    locked = lk_v && (lk_id ? bus.m1_req : bus.m0_req);
    g_v  = 1'b0;
    g_id = 1'b0;
    if (locked) begin
      g_v = 1'b1; g_id = lk_id;
    end else if (bus.m0_req && bus.m1_req) begin
      g_v = 1'b1; g_id = RR ? rr : 1'b0;
    end else if (bus.m0_req) begin
      g_v = 1'b1; g_id = 1'b0;
    end else if (bus.m1_req) begin
      g_v = 1'b1; g_id = 1'b1;
    end
    pop_m  = bus.icu_arb_data_valid && mq.size() > 0;
    e_req  = g_v && (mq.size() < OUTST || pop_m);
    e_addr = !g_v ? 32'h0 : (g_id ? bus.m1_addr : bus.m0_addr);
    e_m0a  = e_req && bus.icu_arb_ack && !g_id;
    e_m1a  = e_req && bus.icu_arb_ack && g_id;
    e_m0d  = 1'b0;
    e_m1d  = 1'b0;
    if (pop_m) begin
      e_m0d = !mq[0].id && !mq[0].kill && !bus.m0_flush;
      e_m1d = mq[0].id && !mq[0].kill;
    end
    e_err = bus.icu_arb_data_valid && mq.size() == 0;
  endtask

  task automatic model_seq();
    bit locked;
    bit push;
    locked = lk_v && (lk_id ? bus.m1_req : bus.m0_req);
    push   = e_req && bus.icu_arb_ack;
    if (pop_m) void'(mq.pop_front());
    if (bus.m0_flush) begin
      foreach (mq[i]) if (!mq[i].id) mq[i].kill = 1'b1;
    end
    if (push) mq.push_back('{id: g_id, kill: 1'b0});
    if (push) lk_v = 1'b0;
    else if (bus.m0_flush && g_v && !g_id) lk_v = 1'b0;
    else if (e_req) begin
      lk_v = 1'b1; lk_id = g_id;
    end else if (!locked) lk_v = 1'b0;
    if (push) rr = !g_id;
  endtask

  function automatic logic [37:0] dut_out();
    return {bus.m0_ack, bus.m0_data_valid, bus.m1_ack,
            bus.m1_data_valid, bus.arb_icu_req, bus.arb_err,
            bus.arb_icu_addr};
  endfunction

  // Called at posedge+1; samples at negedge, leaves at next posedge+1
  task automatic step(input bit r0, input logic [31:0] a0,
                      input bit fl, input bit r1,
                      input logic [31:0] a1, input bit ak,
                      input bit dv, input bit hand,
                      input logic [5:0] heo, input logic [31:0] hea,
                      input string nm);
    logic [37:0] got;
    bus.m0_req = r0;
    bus.m0_addr = a0;
    bus.m0_flush = fl;
    bus.m1_req = r1;
    bus.m1_addr = a1;
    bus.icu_arb_ack = ak;
    bus.icu_arb_data_valid = dv;
    #4;
    model_comb();
    got = dut_out();
    chk({nm, " model"}, got,
        {e_m0a, e_m0d, e_m1a, e_m1d, e_req, e_err, e_addr});
    if (hand) chk({nm, " vec"}, got, {heo, hea});
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0;
    bus.m0_addr = '0;
    bus.m0_flush = 1'b0;
    bus.m1_req = 1'b0;
    bus.m1_addr = '0;
    bus.icu_arb_ack = 1'b0;
    bus.icu_arb_data_valid = 1'b0;
  endtask

  task automatic pulse_reset(input string nm);
    idle_inputs();
    reset = 1'b1;
    #4;
    chk(nm, dut_out(), 38'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic add(input bit r0, input logic [31:0] a0,
                     input bit fl, input bit r1,
                     input logic [31:0] a1, input bit ak,
                     input bit dv, input logic [5:0] eo,
                     input logic [31:0] ea);
    tbl.push_back('{r0: r0, a0: a0, fl: fl, r1: r1, a1: a1,
                    ak: ak, dv: dv, eo: eo, ea: ea});
  endtask

  initial begin
    // eo = {m0_ack, m0_dv, m1_ack, m1_dv, icu_req, err}
    add(0, 32'h0, 0, 0, 32'h0, 0, 0, 6'b000000, 32'h0);
    add(1, 32'h1c000000, 0, 0, 32'h0, 1, 0, 6'b100010, 32'h1c000000);
    add(0, 32'h0, 0, 0, 32'h0, 0, 0, 6'b000000, 32'h0);
    add(0, 32'h0, 0, 0, 32'h0, 0, 1, 6'b010000, 32'h0);
    add(0, 32'h0, 0, 0, 32'h0, 0, 1, 6'b000001, 32'h0);
    add(0, 32'h0, 0, 1, 32'h2000, 0, 0, 6'b000010, 32'h2000);
    add(1, 32'h1000, 0, 1, 32'h2000, 0, 0, 6'b000010, 32'h2000);
    add(1, 32'h1000, 0, 1, 32'h2000, 0, 0, 6'b000010, 32'h2000);
    add(1, 32'h1000, 0, 1, 32'h2000, 1, 0, 6'b001010, 32'h2000);
    add(1, 32'h1000, 0, 0, 32'h0, 1, 0, 6'b100010, 32'h1000);
    add(1, 32'h1004, 0, 0, 32'h0, 1, 0, 6'b000000, 32'h1004);
    add(1, 32'h1004, 0, 0, 32'h0, 1, 1, 6'b100110, 32'h1004);
    add(1, 32'h1008, 1, 0, 32'h0, 1, 1, 6'b100010, 32'h1008);
    add(0, 32'h0, 0, 0, 32'h0, 0, 1, 6'b000000, 32'h0);
    add(0, 32'h0, 0, 0, 32'h0, 0, 1, 6'b010000, 32'h0);
    add(0, 32'h0, 0, 1, 32'h3000, 1, 0, 6'b001010, 32'h3000);
    add(0, 32'h0, 1, 0, 32'h0, 0, 1, 6'b000100, 32'h0);

    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset outputs", dut_out(), 38'h0);
    reset = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      step(tbl[i].r0, tbl[i].a0, tbl[i].fl, tbl[i].r1, tbl[i].a1,
           tbl[i].ak, tbl[i].dv, 1'b1, tbl[i].eo, tbl[i].ea,
           $sformatf("vec%0d", i));
    end

    // Both masters held, ICU acks and returns every cycle
    pulse_reset("reset before contention");
    for (int i = 0; i < 6; i++) begin
      bit m0a, m1a, m0d, m1d;
      m0a = RR ? (i % 2 == 0) : 1'b1;
      m1a = !m0a;
      m0d = (i > 0) && (RR ? ((i - 1) % 2 == 0) : 1'b1);
      m1d = (i > 0) && !m0d;
      step(1, 32'hA0, 0, 1, 32'hB0, 1, i > 0, 1'b1,
           {m0a, m0d, m1a, m1d, 1'b1, 1'b0},
           m0a ? 32'hA0 : 32'hB0, $sformatf("contend%0d", i));
    end

    // Fill to two outstanding, then reset mid-transfer
    step(1, 32'hC0, 0, 0, 32'h0, 1, 0, 1'b1, 6'b100010, 32'hC0,
         "fill");
    step(1, 32'hC4, 0, 0, 32'h0, 1, 0, 1'b1, 6'b000000, 32'hC4,
         "full stall");
    pulse_reset("reset midflight");
    step(0, 32'h0, 0, 0, 32'h0, 0, 1, 1'b1, 6'b000001, 32'h0,
         "orphan after reset");
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, 1'b1, 6'b000000, 32'h0,
         "err one cycle");

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, $urandom, $urandom_range(7) == 0,
           $urandom_range(3) != 0, $urandom, $urandom_range(1) == 1,
           $urandom_range(2) != 0, 1'b0, 6'b0, 32'h0,
           $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
